button_counter_ctrl: RTL

Debounced button controller that drives the LED counter from a raw, asynchronous push-button input. It synchronises and debounces the button and runs a press/release state machine. Each accepted press becomes one counter action: increment, or clear on a long press when the long-press feature is compiled in. It sits between the board button pin and the LEDs and replaces clocking the counter directly from the button.

---
 rtl/button_pkg.sv | 21 ++
 rtl/button_sync.sv | 27 ++
 rtl/button_counter_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and default constants for the button counter controller
//
// Contents:
//   btn_state_t           press/release FSM state encoding
//   DEF_WIDTH             default counter / LED width
//   DEF_DEBOUNCE_CYCLES   default stable cycles needed to accept a level change
//   DEF_LONG_PRESS_CYCLES default hold duration that qualifies as a long press
package button_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } btn_state_t;

  localparam int DEF_WIDTH             = 4;
  localparam int DEF_DEBOUNCE_CYCLES   = 50000;
  localparam int DEF_LONG_PRESS_CYCLES = 25000000;

endpackage

// File: rtl/button_sync.sv
// rtl/button_sync.sv - two-flop synchroniser for the asynchronous button level
//
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset, clears both flops
//   d    in   asynchronous level
//   q    out  level synchronised to clk, two cycles behind d
module button_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_counter_ctrl.sv
// rtl/button_counter_ctrl.sv - debounced push-button controller driving the LED counter
//
// Optional feature macro: BUTTON_CTRL_LONGPRESS_EN
//   undefined: each accepted press increments the counter at press acceptance
//   defined:   action taken at release acceptance; a hold of at least
//              LONG_PRESS_CYCLES clears the counter instead of incrementing
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   OUT          in   raw asynchronous button level, active-high
//   led          out  current count (WIDTH bits, wraps modulo 2^WIDTH)
//   press_pulse  out  one-cycle strobe per accepted increment
//   clear_pulse  out  one-cycle strobe per long-press clear (0 without the feature)
module button_counter_ctrl
  import button_pkg::*;
#(
  parameter int WIDTH             = DEF_WIDTH,
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             OUT,
  output logic [WIDTH-1:0] led,
  output logic             press_pulse,
  output logic             clear_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);

  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
    $error("button_counter_ctrl: need DEBOUNCE_CYCLES >= 2 and LONG_PRESS_CYCLES > DEBOUNCE_CYCLES");
  end

  logic             s;
  btn_state_t       state, state_nx;
  logic [DW-1:0]    dcnt, dcnt_nx;
  logic [WIDTH-1:0] count, count_nx;
  logic             press_nx;

`ifdef BUTTON_CTRL_LONGPRESS_EN
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);

  logic [HW-1:0] hcnt, hcnt_nx, hcnt_inc;
  logic          clear_nx;

  // Hold timer saturates so very long holds never wrap back to "short".
  assign hcnt_inc = (hcnt >= HOLD_MAX) ? hcnt : hcnt + 1'b1;
`endif

  button_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (OUT),
    .q   (s)
  );

  always_comb begin
    state_nx = state;
    dcnt_nx  = dcnt;
    count_nx = count;
    press_nx = 1'b0;
`ifdef BUTTON_CTRL_LONGPRESS_EN
    hcnt_nx  = hcnt;
    clear_nx = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (s) begin
          state_nx = DEB_PRESS;
          dcnt_nx  = DEB_ONE;
        end
      end
      DEB_PRESS: begin
        if (!s) begin
          state_nx = IDLE;
        end else if (dcnt == DEB_LAST) begin
          state_nx = PRESSED;
`ifdef BUTTON_CTRL_LONGPRESS_EN
          hcnt_nx  = '0;
`else
          count_nx = count + 1'b1;
          press_nx = 1'b1;
`endif
        end else begin
          dcnt_nx = dcnt + 1'b1;
        end
      end
      PRESSED: begin
`ifdef BUTTON_CTRL_LONGPRESS_EN
        hcnt_nx = hcnt_inc;
`endif
        if (!s) begin
          state_nx = DEB_RELEASE;
          dcnt_nx  = DEB_ONE;
        end
      end
      DEB_RELEASE: begin
        // The hold keeps timing through release debounce, so a bounce on
        // release does not shorten the measured hold.
`ifdef BUTTON_CTRL_LONGPRESS_EN
        hcnt_nx = hcnt_inc;
`endif
        if (s) begin
          state_nx = PRESSED;
        end else if (dcnt == DEB_LAST) begin
          state_nx = IDLE;
`ifdef BUTTON_CTRL_LONGPRESS_EN
          if (hcnt >= HOLD_MAX) begin
            count_nx = '0;
            clear_nx = 1'b1;
          end else begin
            count_nx = count + 1'b1;
            press_nx = 1'b1;
          end
`endif
        end else begin
          dcnt_nx = dcnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dcnt        <= '0;
      count       <= '0;
      press_pulse <= 1'b0;
    end else begin
      state       <= state_nx;
      dcnt        <= dcnt_nx;
      count       <= count_nx;
      press_pulse <= press_nx;
    end
  end

`ifdef BUTTON_CTRL_LONGPRESS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt        <= '0;
      clear_pulse <= 1'b0;
    end else begin
      hcnt        <= hcnt_nx;
      clear_pulse <= clear_nx;
    end
  end
`else
  assign clear_pulse = 1'b0;
`endif

  assign led = count;

endmodule
